// File: rtl/sram_bank_array.sv
// Banked SRAM array of sky130 1rw1r macros serving an OBI data port (rw, macro port 0)
// and an OBI instruction port (ro, macro port 1), with collision stalls and error capture.

`ifndef SRAM_BANK_ARRAY_NO_MACRO_MODEL
// Cycle-level stand-in for the hard macro; a real netlist build defines the guard above.
module sky130_sram_2kbyte_1rw1r_32x512_8 (
`ifdef USE_POWER_PINS
  inout  wire         vccd1,
  inout  wire         vssd1,
`endif
  input  logic        clk0,
  input  logic        csb0,
  input  logic        web0,
  input  logic [3:0]  wmask0,
  input  logic [8:0]  addr0,
  input  logic [31:0] din0,
  output logic [31:0] dout0,
  input  logic        clk1,
  input  logic        csb1,
  input  logic [8:0]  addr1,
  output logic [31:0] dout1
);
  logic [31:0] r_mem [512];

  // Port 0: masked write or read, selected by web0.
  always_ff @(posedge clk0) begin
    if (!csb0) begin
      if (!web0) begin
        for (int b = 0; b < 4; b++) begin
          if (wmask0[b]) begin
            r_mem[addr0][8*b +: 8] <= din0[8*b +: 8];
          end
        end
      end else begin
        dout0 <= r_mem[addr0];
      end
    end
  end

  // Port 1: read only.
  always_ff @(posedge clk1) begin
    if (!csb1) begin
      dout1 <= r_mem[addr1];
    end
  end
endmodule
`endif

module sram_bank_array #(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          NUM_BLOCKS  = 4,
  parameter int          BLOCK_WORDS = 512,
  parameter bit          OUT_REG     = 1'b0,
  parameter logic [31:0] ERR_DATA    = 32'hDEAD_BEEF
) (
`ifdef USE_POWER_PINS
  inout  wire         vccd1,
  inout  wire         vssd1,
`endif
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        d_req_i,
  output logic        d_gnt_o,
  input  logic [31:0] d_addr_i,
  input  logic        d_we_i,
  input  logic [3:0]  d_be_i,
  input  logic [31:0] d_wdata_i,
  output logic        d_rvalid_o,
  output logic [31:0] d_rdata_o,
  output logic        d_err_o,
  input  logic        i_req_i,
  output logic        i_gnt_o,
  input  logic [31:0] i_addr_i,
  input  logic        i_we_i,
  output logic        i_rvalid_o,
  output logic [31:0] i_rdata_o,
  output logic        i_err_o,
  input  logic        err_clr_i,
  output logic        err_sticky_o,
  output logic [31:0] err_addr_o,
  output logic        err_src_o
);
  localparam int          LOG_WORDS  = $clog2(BLOCK_WORDS);
  localparam int          LOG_BLOCKS = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
  localparam logic [32:0] BASE_EXT   = {1'b0, BASE_ADDR};
  localparam logic [32:0] END_ADDR   = BASE_EXT + 33'(NUM_BLOCKS * BLOCK_WORDS * 4);

  logic                  w_d_legal, w_i_legal, w_collision, w_i_gnt;
  logic                  w_d_ill, w_i_ill;
  logic [LOG_BLOCKS-1:0] w_d_bank, w_i_bank;
  logic [LOG_WORDS-1:0]  w_d_word, w_i_word;
  logic [NUM_BLOCKS-1:0] w_d_sel, w_i_sel;
  logic [31:0]           w_dout0 [NUM_BLOCKS];
  logic [31:0]           w_dout1 [NUM_BLOCKS];
  logic [31:0]           w_d_mux, w_i_mux, w_d_rdata, w_i_rdata;

  logic                  r_d_vld, r_d_err, r_d_we, r_i_vld, r_i_err;
  logic [NUM_BLOCKS-1:0] r_d_bsel, r_i_bsel;
  logic                  r_err_sticky, r_err_src;
  logic [31:0]           r_err_addr;

  assign w_d_bank  = d_addr_i[LOG_BLOCKS+LOG_WORDS+1 : LOG_WORDS+2];
  assign w_i_bank  = i_addr_i[LOG_BLOCKS+LOG_WORDS+1 : LOG_WORDS+2];
  assign w_d_word  = d_addr_i[LOG_WORDS+1 : 2];
  assign w_i_word  = i_addr_i[LOG_WORDS+1 : 2];
  assign w_d_legal = ({1'b0, d_addr_i} >= BASE_EXT) && ({1'b0, d_addr_i} < END_ADDR);
  assign w_i_legal = ({1'b0, i_addr_i} >= BASE_EXT) && ({1'b0, i_addr_i} < END_ADDR) && !i_we_i;

  // A same-word write stalls the instruction read one cycle so it returns the new data.
  assign w_collision = d_req_i && d_we_i && w_d_legal && i_req_i && w_i_legal &&
                       (w_d_bank == w_i_bank) && (w_d_word == w_i_word);
  assign d_gnt_o = d_req_i;
  assign w_i_gnt = i_req_i && !w_collision;
  assign i_gnt_o = w_i_gnt;
  assign w_d_ill = d_req_i && !w_d_legal;
  assign w_i_ill = i_req_i && !w_i_legal;

  // One-hot chip selects for legal grants only.
  always_comb begin
    w_d_sel = '0;
    w_i_sel = '0;
    for (int j = 0; j < NUM_BLOCKS; j++) begin
      w_d_sel[j] = d_req_i && w_d_legal && (w_d_bank == LOG_BLOCKS'(j));
      w_i_sel[j] = w_i_gnt && w_i_legal && (w_i_bank == LOG_BLOCKS'(j));
    end
  end

  for (genvar j = 0; j < NUM_BLOCKS; j++) begin : g_bank
    sky130_sram_2kbyte_1rw1r_32x512_8 u_macro (
`ifdef USE_POWER_PINS
      .vccd1  (vccd1),
      .vssd1  (vssd1),
`endif
      .clk0   (clk_i),
      .csb0   (~w_d_sel[j]),
      .web0   (~d_we_i),
      .wmask0 (d_be_i),
      .addr0  (w_d_word),
      .din0   (d_wdata_i),
      .dout0  (w_dout0[j]),
      .clk1   (clk_i),
      .csb1   (~w_i_sel[j]),
      .addr1  (w_i_word),
      .dout1  (w_dout1[j])
    );
  end

  // Per-port response history captured at grant.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_d_vld  <= 1'b0;
      r_d_err  <= 1'b0;
      r_d_we   <= 1'b0;
      r_d_bsel <= '0;
      r_i_vld  <= 1'b0;
      r_i_err  <= 1'b0;
      r_i_bsel <= '0;
    end else begin
      r_d_vld  <= d_req_i;
      r_d_err  <= w_d_ill;
      r_d_we   <= d_req_i && d_we_i;
      r_d_bsel <= w_d_sel;
      r_i_vld  <= w_i_gnt;
      r_i_err  <= w_i_gnt && !w_i_legal;
      r_i_bsel <= w_i_sel;
    end
  end

  // Read-data mux; missing select or error flag yields ERR_DATA.
  always_comb begin
    w_d_mux = 32'h0000_0000;
    w_i_mux = 32'h0000_0000;
    for (int j = 0; j < NUM_BLOCKS; j++) begin
      w_d_mux = w_d_mux | (w_dout0[j] & {32{r_d_bsel[j]}});
      w_i_mux = w_i_mux | (w_dout1[j] & {32{r_i_bsel[j]}});
    end
    if (r_d_err || (r_d_bsel == '0)) begin
      w_d_rdata = ERR_DATA;
    end else if (r_d_we) begin
      w_d_rdata = 32'h0000_0000;
    end else begin
      w_d_rdata = w_d_mux;
    end
    if (r_i_err || (r_i_bsel == '0)) begin
      w_i_rdata = ERR_DATA;
    end else begin
      w_i_rdata = w_i_mux;
    end
  end

  if (OUT_REG) begin : g_oreg
    logic        r_d_vld_q, r_d_err_q, r_i_vld_q, r_i_err_q;
    logic [31:0] r_d_rdata_q, r_i_rdata_q;

    // Optional output stage adds one cycle of read latency.
    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        r_d_vld_q   <= 1'b0;
        r_d_err_q   <= 1'b0;
        r_d_rdata_q <= 32'h0000_0000;
        r_i_vld_q   <= 1'b0;
        r_i_err_q   <= 1'b0;
        r_i_rdata_q <= 32'h0000_0000;
      end else begin
        r_d_vld_q   <= r_d_vld;
        r_d_err_q   <= r_d_err;
        r_d_rdata_q <= w_d_rdata;
        r_i_vld_q   <= r_i_vld;
        r_i_err_q   <= r_i_err;
        r_i_rdata_q <= w_i_rdata;
      end
    end

    assign d_rvalid_o = r_d_vld_q;
    assign d_err_o    = r_d_err_q;
    assign d_rdata_o  = r_d_rdata_q;
    assign i_rvalid_o = r_i_vld_q;
    assign i_err_o    = r_i_err_q;
    assign i_rdata_o  = r_i_rdata_q;
  end else begin : g_noreg
    assign d_rvalid_o = r_d_vld;
    assign d_err_o    = r_d_err;
    assign d_rdata_o  = w_d_rdata;
    assign i_rvalid_o = r_i_vld;
    assign i_err_o    = r_i_err;
    assign i_rdata_o  = w_i_rdata;
  end

  // Sticky capture of the first illegal access; a new error beats a simultaneous clear.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_err_sticky <= 1'b0;
      r_err_addr   <= 32'h0000_0000;
      r_err_src    <= 1'b0;
    end else if ((!r_err_sticky || err_clr_i) && (w_d_ill || w_i_ill)) begin
      r_err_sticky <= 1'b1;
      r_err_addr   <= w_d_ill ? d_addr_i : i_addr_i;
      r_err_src    <= !w_d_ill;
    end else if (err_clr_i) begin
      r_err_sticky <= 1'b0;
    end
  end

  assign err_sticky_o = r_err_sticky;
  assign err_addr_o   = r_err_addr;
  assign err_src_o    = r_err_src;
endmodule

// File: tb/tb_sram_bank_array.sv
// Directed bench: two instances (OUT_REG=0 and OUT_REG=1) share stimulus; expectations are hand-computed.
module tb_sram_bank_array;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, d_req, d_we, i_req, i_we, err_clr;
  logic [31:0] d_addr, d_wdata, i_addr;
  logic [3:0]  d_be;

  logic        d_gnt0, d_rvalid0, d_err0, i_gnt0, i_rvalid0, i_err0, err_sticky0, err_src0;
  logic [31:0] d_rdata0, i_rdata0, err_addr0;
  logic        d_gnt1, d_rvalid1, d_err1, i_gnt1, i_rvalid1, i_err1, err_sticky1, err_src1;
  logic [31:0] d_rdata1, i_rdata1, err_addr1;

  int checks = 0;
  int errors = 0;

  sram_bank_array #(.OUT_REG(1'b0)) dut0 (
    .clk_i(clk), .rst_ni(rst_n),
    .d_req_i(d_req), .d_gnt_o(d_gnt0), .d_addr_i(d_addr), .d_we_i(d_we), .d_be_i(d_be),
    .d_wdata_i(d_wdata), .d_rvalid_o(d_rvalid0), .d_rdata_o(d_rdata0), .d_err_o(d_err0),
    .i_req_i(i_req), .i_gnt_o(i_gnt0), .i_addr_i(i_addr), .i_we_i(i_we),
    .i_rvalid_o(i_rvalid0), .i_rdata_o(i_rdata0), .i_err_o(i_err0),
    .err_clr_i(err_clr), .err_sticky_o(err_sticky0), .err_addr_o(err_addr0), .err_src_o(err_src0)
  );

  sram_bank_array #(.OUT_REG(1'b1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n),
    .d_req_i(d_req), .d_gnt_o(d_gnt1), .d_addr_i(d_addr), .d_we_i(d_we), .d_be_i(d_be),
    .d_wdata_i(d_wdata), .d_rvalid_o(d_rvalid1), .d_rdata_o(d_rdata1), .d_err_o(d_err1),
    .i_req_i(i_req), .i_gnt_o(i_gnt1), .i_addr_i(i_addr), .i_we_i(i_we),
    .i_rvalid_o(i_rvalid1), .i_rdata_o(i_rdata1), .i_err_o(i_err1),
    .err_clr_i(err_clr), .err_sticky_o(err_sticky1), .err_addr_o(err_addr1), .err_src_o(err_src1)
  );

  task automatic idle();
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_be = 4'h0; d_wdata = 32'h0;
    i_req = 1'b0; i_we = 1'b0; i_addr = 32'h0; err_clr = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic d_drive(input logic we, input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wd);
    d_req = 1'b1; d_we = we; d_addr = addr; d_be = be; d_wdata = wd;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    step();
    step();
    checks++; if (d_rvalid0 !== 1'b0) begin errors++; $display("FAIL rst_d_rvalid got %0h exp 0", d_rvalid0); end
    checks++; if (i_rvalid0 !== 1'b0) begin errors++; $display("FAIL rst_i_rvalid got %0h exp 0", i_rvalid0); end
    checks++; if (d_err0 !== 1'b0 || i_err0 !== 1'b0) begin errors++; $display("FAIL rst_err got %0h/%0h exp 0/0", d_err0, i_err0); end
    checks++; if (err_sticky0 !== 1'b0) begin errors++; $display("FAIL rst_sticky got %0h exp 0", err_sticky0); end
    checks++; if (err_addr0 !== 32'h0 || err_src0 !== 1'b0) begin errors++; $display("FAIL rst_capture got %h/%0h exp 0/0", err_addr0, err_src0); end
    checks++; if (d_rvalid1 !== 1'b0 || i_rvalid1 !== 1'b0) begin errors++; $display("FAIL rst_oreg_rvalid got %0h/%0h exp 0/0", d_rvalid1, i_rvalid1); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_data_path();
    d_drive(1'b1, 32'h8000_0804, 4'hF, 32'h1234_5678);
    #1;
    checks++; if (d_gnt0 !== 1'b1) begin errors++; $display("FAIL dp_gnt got %0h exp 1", d_gnt0); end
    step();
    checks++; if (d_rvalid0 !== 1'b1 || d_rdata0 !== 32'h0 || d_err0 !== 1'b0) begin errors++; $display("FAIL dp_wr_resp got v%0h d%h e%0h exp v1 d00000000 e0", d_rvalid0, d_rdata0, d_err0); end
    checks++; if (d_rvalid1 !== 1'b0) begin errors++; $display("FAIL dp_oreg_early got %0h exp 0", d_rvalid1); end
    d_we = 1'b0;
    step();
    checks++; if (d_rvalid0 !== 1'b1 || d_rdata0 !== 32'h1234_5678 || d_err0 !== 1'b0) begin errors++; $display("FAIL dp_rd_resp got v%0h d%h e%0h exp v1 d12345678 e0", d_rvalid0, d_rdata0, d_err0); end
    checks++; if (d_rvalid1 !== 1'b1 || d_rdata1 !== 32'h0) begin errors++; $display("FAIL dp_oreg_wr_resp got v%0h d%h exp v1 d00000000", d_rvalid1, d_rdata1); end
    idle();
    step();
    checks++; if (d_rvalid0 !== 1'b0) begin errors++; $display("FAIL dp_idle got %0h exp 0", d_rvalid0); end
    checks++; if (d_rvalid1 !== 1'b1 || d_rdata1 !== 32'h1234_5678 || d_err1 !== 1'b0) begin errors++; $display("FAIL dp_oreg_rd_resp got v%0h d%h e%0h exp v1 d12345678 e0", d_rvalid1, d_rdata1, d_err1); end
    step();
    checks++; if (d_rvalid1 !== 1'b0) begin errors++; $display("FAIL dp_oreg_idle got %0h exp 0", d_rvalid1); end
  endtask

  task automatic test_byte_enables();
    d_drive(1'b1, 32'h8000_1FFC, 4'hF, 32'hFFFF_FFFF);
    step();
    d_drive(1'b1, 32'h8000_1FFC, 4'b0101, 32'hAABB_CCDD);
    step();
    d_drive(1'b0, 32'h8000_1FFC, 4'hF, 32'h0);
    step();
    checks++; if (d_rdata0 !== 32'hFFBB_FFDD || d_err0 !== 1'b0) begin errors++; $display("FAIL be_merge got %h e%0h exp ffbbffdd e0", d_rdata0, d_err0); end
    idle();
    step();
  endtask

  task automatic test_collision();
    d_drive(1'b1, 32'h8000_0010, 4'hF, 32'hCAFE_F00D);
    i_req = 1'b1; i_we = 1'b0; i_addr = 32'h8000_0010;
    #1;
    checks++; if (i_gnt0 !== 1'b0 || d_gnt0 !== 1'b1) begin errors++; $display("FAIL col_stall got i%0h d%0h exp i0 d1", i_gnt0, d_gnt0); end
    step();
    checks++; if (i_rvalid0 !== 1'b0) begin errors++; $display("FAIL col_no_early_resp got %0h exp 0", i_rvalid0); end
    d_req = 1'b0; d_we = 1'b0;
    #1;
    checks++; if (i_gnt0 !== 1'b1) begin errors++; $display("FAIL col_regrant got %0h exp 1", i_gnt0); end
    step();
    checks++; if (i_rvalid0 !== 1'b1 || i_rdata0 !== 32'hCAFE_F00D || i_err0 !== 1'b0) begin errors++; $display("FAIL col_new_data got v%0h d%h e%0h exp v1 dcafef00d e0", i_rvalid0, i_rdata0, i_err0); end
    idle();
    d_drive(1'b1, 32'h8000_0014, 4'hF, 32'h5566_7788);
    step();
    d_drive(1'b1, 32'h8000_0010, 4'hF, 32'h1111_2222);
    i_req = 1'b1; i_addr = 32'h8000_0014;
    #1;
    checks++; if (i_gnt0 !== 1'b1 || d_gnt0 !== 1'b1) begin errors++; $display("FAIL nocol_gnt got i%0h d%0h exp i1 d1", i_gnt0, d_gnt0); end
    step();
    checks++; if (i_rvalid0 !== 1'b1 || i_rdata0 !== 32'h5566_7788) begin errors++; $display("FAIL nocol_rdata got v%0h d%h exp v1 d55667788", i_rvalid0, i_rdata0); end
    idle();
    step();
  endtask

  task automatic test_back_to_back();
    d_drive(1'b0, 32'h8000_0804, 4'hF, 32'h0);
    step();
    d_drive(1'b0, 32'h8000_0010, 4'hF, 32'h0);
    checks++; if (d_rvalid0 !== 1'b1 || d_rdata0 !== 32'h1234_5678) begin errors++; $display("FAIL b2b_first got v%0h d%h exp v1 d12345678", d_rvalid0, d_rdata0); end
    step();
    checks++; if (d_rvalid0 !== 1'b1 || d_rdata0 !== 32'h1111_2222) begin errors++; $display("FAIL b2b_second got v%0h d%h exp v1 d11112222", d_rvalid0, d_rdata0); end
    checks++; if (d_rvalid1 !== 1'b1 || d_rdata1 !== 32'h1234_5678) begin errors++; $display("FAIL b2b_oreg_first got v%0h d%h exp v1 d12345678", d_rvalid1, d_rdata1); end
    idle();
    step();
    checks++; if (d_rvalid1 !== 1'b1 || d_rdata1 !== 32'h1111_2222) begin errors++; $display("FAIL b2b_oreg_second got v%0h d%h exp v1 d11112222", d_rvalid1, d_rdata1); end
    step();
  endtask

  task automatic test_range_errors();
    checks++; if (err_sticky0 !== 1'b0) begin errors++; $display("FAIL re_pre_sticky got %0h exp 0", err_sticky0); end
    d_drive(1'b0, 32'h8000_2000, 4'hF, 32'h0);
    i_req = 1'b1; i_addr = 32'h7FFF_FFFC;
    #1;
    checks++; if (d_gnt0 !== 1'b1 || i_gnt0 !== 1'b1) begin errors++; $display("FAIL re_gnt got d%0h i%0h exp d1 i1", d_gnt0, i_gnt0); end
    step();
    checks++; if (d_rvalid0 !== 1'b1 || d_err0 !== 1'b1 || d_rdata0 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL re_d_resp got v%0h e%0h d%h exp v1 e1 ddeadbeef", d_rvalid0, d_err0, d_rdata0); end
    checks++; if (i_rvalid0 !== 1'b1 || i_err0 !== 1'b1 || i_rdata0 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL re_i_resp got v%0h e%0h d%h exp v1 e1 ddeadbeef", i_rvalid0, i_err0, i_rdata0); end
    checks++; if (err_sticky0 !== 1'b1 || err_addr0 !== 32'h8000_2000 || err_src0 !== 1'b0) begin errors++; $display("FAIL re_capture got s%0h a%h src%0h exp s1 a80002000 src0", err_sticky0, err_addr0, err_src0); end
    idle();
    i_req = 1'b1; i_addr = 32'h9000_0000;
    step();
    checks++; if (i_err0 !== 1'b1) begin errors++; $display("FAIL re_later_err got %0h exp 1", i_err0); end
    checks++; if (err_addr0 !== 32'h8000_2000 || err_src0 !== 1'b0) begin errors++; $display("FAIL re_hold got a%h src%0h exp a80002000 src0", err_addr0, err_src0); end
    i_addr = 32'h7FFF_FFFC;
    err_clr = 1'b1;
    step();
    checks++; if (err_sticky0 !== 1'b1 || err_addr0 !== 32'h7FFF_FFFC || err_src0 !== 1'b1) begin errors++; $display("FAIL re_set_wins got s%0h a%h src%0h exp s1 a7ffffffc src1", err_sticky0, err_addr0, err_src0); end
    idle();
    err_clr = 1'b1;
    step();
    checks++; if (err_sticky0 !== 1'b0) begin errors++; $display("FAIL re_clear got %0h exp 0", err_sticky0); end
    idle();
    step();
  endtask

  task automatic test_illegal_iwrite();
    d_drive(1'b1, 32'h8000_0000, 4'hF, 32'h0102_0304);
    step();
    idle();
    i_req = 1'b1; i_we = 1'b1; i_addr = 32'h8000_0000;
    #1;
    checks++; if (i_gnt0 !== 1'b1) begin errors++; $display("FAIL iw_gnt got %0h exp 1", i_gnt0); end
    step();
    checks++; if (i_rvalid0 !== 1'b1 || i_err0 !== 1'b1 || i_rdata0 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL iw_resp got v%0h e%0h d%h exp v1 e1 ddeadbeef", i_rvalid0, i_err0, i_rdata0); end
    checks++; if (err_sticky0 !== 1'b1 || err_addr0 !== 32'h8000_0000 || err_src0 !== 1'b1) begin errors++; $display("FAIL iw_capture got s%0h a%h src%0h exp s1 a80000000 src1", err_sticky0, err_addr0, err_src0); end
    idle();
    d_drive(1'b0, 32'h8000_0000, 4'hF, 32'h0);
    step();
    checks++; if (d_rdata0 !== 32'h0102_0304 || d_err0 !== 1'b0) begin errors++; $display("FAIL iw_mem_unchanged got %h e%0h exp 01020304 e0", d_rdata0, d_err0); end
    idle();
    err_clr = 1'b1;
    step();
    idle();
  endtask

  task automatic test_reset_mid();
    d_drive(1'b0, 32'h8000_0804, 4'hF, 32'h0);
    i_req = 1'b1; i_addr = 32'h7FFF_FFFC;
    step();
    checks++; if (err_sticky0 !== 1'b1) begin errors++; $display("FAIL rm_pre_sticky got %0h exp 1", err_sticky0); end
    idle();
    rst_n = 1'b0;
    step();
    checks++; if (d_rvalid0 !== 1'b0 || d_rvalid1 !== 1'b0 || i_rvalid0 !== 1'b0 || i_rvalid1 !== 1'b0) begin errors++; $display("FAIL rm_rvalid got %0h%0h%0h%0h exp 0000", d_rvalid0, d_rvalid1, i_rvalid0, i_rvalid1); end
    checks++; if (err_sticky0 !== 1'b0 || err_addr0 !== 32'h0 || err_src0 !== 1'b0) begin errors++; $display("FAIL rm_capture got s%0h a%h src%0h exp s0 a00000000 src0", err_sticky0, err_addr0, err_src0); end
    checks++; if (d_err0 !== 1'b0 || i_err0 !== 1'b0 || i_err1 !== 1'b0) begin errors++; $display("FAIL rm_err got %0h%0h%0h exp 000", d_err0, i_err0, i_err1); end
    rst_n = 1'b1;
    step();
    checks++; if (d_rvalid0 !== 1'b0 || d_rvalid1 !== 1'b0 || i_rvalid1 !== 1'b0) begin errors++; $display("FAIL rm_no_late_rvalid got %0h%0h%0h exp 000", d_rvalid0, d_rvalid1, i_rvalid1); end
  endtask

  initial begin
    test_reset();
    test_data_path();
    test_byte_enables();
    test_collision();
    test_back_to_back();
    test_range_errors();
    test_illegal_iwrite();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sram_bank_array.md
Name: sram_bank_array

Overview:
- Parametrised successor to the single-macro SRAM wrapper. Instantiates NUM_BLOCKS sky130_sram_2kbyte_1rw1r_32x512_8 macros through a generate loop.
- Serves two OBI ports:
  - data port: read/write, mapped to macro port 0;
  - instruction port: read-only, mapped to macro port 1.
- Adds same-word write/read collision stalling, an optional output register stage, per-port error responses and a sticky error-capture register for the system bus.

Parameters:
- BASE_ADDR, 32'h8000_0000, byte base address of the array.
- NUM_BLOCKS, 4, number of macros (1..16).
- BLOCK_WORDS, 512, 32-bit words per macro; fixed by the macro.
- OUT_REG, 0, 1 inserts a read-data register; read latency becomes 2.
- ERR_DATA, 32'hDEAD_BEEF, rdata returned on error responses.
- Derived:
  - LOG_WORDS = $clog2(BLOCK_WORDS);
  - LOG_BLOCKS = max(1, $clog2(NUM_BLOCKS));
  - END_ADDR = BASE_ADDR + NUM_BLOCKS*BLOCK_WORDS*4, exclusive, in bytes.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- d_req_i  in  1  data OBI request
- d_gnt_o  out  1  data grant
- d_addr_i  in  32  data byte address
- d_we_i  in  1  data write enable
- d_be_i  in  4  data byte enables
- d_wdata_i  in  32  data write data
- d_rvalid_o  out  1  data response valid
- d_rdata_o  out  32  data read data
- d_err_o  out  1  data error, valid with d_rvalid_o
- i_req_i  in  1  instruction OBI request
- i_gnt_o  out  1  instruction grant
- i_addr_i  in  32  instruction byte address
- i_we_i  in  1  instruction write enable; any write is illegal
- i_rvalid_o  out  1  instruction response valid
- i_rdata_o  out  32  instruction read data
- i_err_o  out  1  instruction error, valid with i_rvalid_o
- err_clr_i  in  1  clears the sticky error register
- err_sticky_o  out  1  sticky error flag
- err_addr_o  out  32  address of the first error since the last clear
- err_src_o  out  1  source of that error: 0 = data, 1 = instruction

Behaviour:
- Reset values when rst_ni=0 at a clock edge:
  - all rvalid, err, err_sticky_o = 0;
  - err_addr_o = 0; err_src_o = 0;
  - chip-select history registers = 0.
- gnt is combinational. Responses in flight at reset are dropped; no rvalid follows reset.
- Decode:
  - in-range means BASE_ADDR <= addr < END_ADDR;
  - bank = addr[LOG_BLOCKS+LOG_WORDS+1 : LOG_WORDS+2];
  - word = addr[LOG_WORDS+1 : 2];
  - addr[1:0] is ignored.
- Illegal request conditions:
  - out of range on either port;
  - i_we_i=1 on the instruction port.
- Illegal requests:
  - are granted in the same cycle;
  - assert no macro chip select;
  - return a response with rdata=ERR_DATA and err=1 after the normal latency.
- Grant rules:
  - d_gnt_o = d_req_i, always.
  - i_gnt_o = i_req_i, except during a collision.
  - Collision: d_req_i and d_we_i, i_req_i, both legal, same bank and same word in the same cycle.
  - On collision: i_gnt_o=0, the instruction macro chip select is held inactive, and the write proceeds.
  - The master holds i_req_i (OBI rule), so the read is granted next cycle and returns the new data.
  - A same-bank, different-word access is not a collision; both ports proceed.
- Latency:
  - response in cycle N+1 after a grant in cycle N when OUT_REG=0; N+2 when OUT_REG=1.
  - Back-to-back requests sustain 1 response per cycle in order.
- Write responses: d_rvalid_o=1 at the read latency, d_rdata_o=0, d_err_o=0.
- Read data muxing:
  - each port registers its one-hot bank select and an error bit at grant;
  - data is muxed from the selected macro dout;
  - with no select, or with the error bit set, the port returns ERR_DATA.
- Sticky error register:
  - on any illegal grant while err_sticky_o=0: set err_sticky_o; capture the address and source.
  - If both ports are illegal in the same cycle, the data port wins capture.
  - Later errors do not overwrite the capture until cleared.
  - err_clr_i=1 clears the flag. If a new error occurs in the same cycle as the clear, the new error is captured (set wins).
- Macro hookup per bank j:
  - csb0 = ~(d legal grant & bank==j);
  - web0 = ~d_we_i; wmask0 = d_be_i;
  - addr0 = word; din0 = d_wdata_i;
  - csb1 = ~(i legal grant & bank==j); addr1 = i word.
- Power pins are passed through under USE_POWER_PINS.

Test Plan:
- Data path: write 0x1234_5678 to 0x8000_0804 with be=4'hF, then read it on the data port:
  - OUT_REG=0: rvalid 1 cycle after grant, rdata=0x1234_5678, err=0;
  - OUT_REG=1: rvalid 2 cycles after grant.
- Byte enables: write 0xAABB_CCDD with be=4'b0101 over 0xFFFF_FFFF at 0x8000_1FFC (last word of bank 3), then read → 0xFFBB_FFDD.
- Collision: the data port writes 0xCAFE_F00D to 0x8000_0010 while the instruction port reads 0x8000_0010 in the same cycle:
  - i_gnt_o=0 that cycle, then 1 the next cycle;
  - i_rdata_o=0xCAFE_F00D.
  - Repeat with the instruction port reading 0x8000_0014 → both ports are granted in the same cycle.
- Range errors:
  - a data read at 0x8000_2000 → err=1, rdata=0xDEAD_BEEF;
  - an instruction read at 0x7FFF_FFFC in the same cycle → err=1;
  - err_addr_o=0x8000_2000, err_src_o=0;
  - a later error leaves the capture unchanged; err_clr_i → sticky=0.
- Illegal instruction write: an instruction write at 0x8000_0000 → i_err_o=1, memory unchanged (a data-port readback returns the old value).
- Reset mid-operation: a read is granted, then rst_ni=0 in the next cycle → no rvalid, all outputs at their reset values, no error captured.
